led_mode_ctrl: RTL and testbench
================================

# led_mode_ctrl

Sequencer for the 4-LED bank, driven by single-cycle key-press pulses from the key debounce/edge-detect stage. It selects one of four display modes, paces pattern updates from a programmable prescaler with four speed levels, and supports pause/resume. It sits between the debounced key events and the board LED pins; LEDs are active-low, so 1 = off.

## Interface
- TICK_DIV, default 12_500_000: base pattern period in clk cycles at speed 0; legal range ≥ 8 and < 2^CW.
- CW, default 24: prescaler width.
- clk  in  1  system clock
- rest  in  1  reset; one clock; reset is synchronous and active-low
- key_evt  in  4  one-cycle press pulses, mapped as:
  - [0] next mode
  - [1] speed up
  - [2] speed down
  - [3] pause toggle
- led  out  4  LED drive, active-low
- mode  out  2  current mode: 0 IDLE, 1 RUN, 2 BLINK, 3 COUNT
- speed  out  2  speed level, 0 slowest
- paused  out  1  high while pattern is frozen

## Operation
- **Reset** (rest low at a posedge):
  - led = 4'b1111, mode = IDLE, speed = 0, paused = 0
  - prescaler = 0, COUNT register = 0
- **Event priority.** At most one event is honoured per cycle, in order key_evt[3] > [0] > [1] > [2]; lower-priority events in the same cycle are dropped.
- **[3] pause toggle:** paused flips and prescaler clears to 0. While paused, prescaler holds, no ticks occur, led is frozen, and the other keys still act.
- **[0] next mode:** IDLE→RUN→BLINK→COUNT→IDLE. Prescaler clears and the pattern loads the new mode's initial value:
  - IDLE 1111
  - RUN 1110
  - BLINK 0000
  - COUNT: count = 0, so led 1111
- **[1] / [2] speed up / down:** speed increments or decrements, saturating at 3 and 0. Prescaler clears; the pattern is unchanged.
- **Period:** period = TICK_DIV >> speed.
- **Tick:** fires when prescaler == period−1 and not paused. Prescaler then wraps to 0 and the pattern advances:
  - IDLE: stays 1111
  - RUN: rotate left, 1110→1101→1011→0111→1110
  - BLINK: led inverts
  - COUNT: count += 1 mod 16, led = ~count
- **Tick coincident with any honoured event:** the event wins and the tick is dropped; no advance that cycle.
- **Speed change** clears the prescaler, so there is no partial period at the new speed. Prescaler never exceeds period−1.

## Timing
- All outputs are registered. An event or tick at posedge N is visible on outputs after N.
- After any prescaler clear at edge N, the first tick occurs at edge N+period.
- Steady state: one pattern step every period cycles.
- Reset takes priority over all events and ticks, and takes effect at the first posedge with rest low, including mid-pattern or mid-pause.
- key_evt is assumed synchronous to clk, one cycle wide, and already debounced.

## Structure
- **Package led_ctrl_pkg:**
  - mode encoding constants MODE_IDLE / MODE_RUN / MODE_BLINK / MODE_COUNT
  - LED_OFF = 4'b1111, RUN_INIT = 4'b1110, BLINK_INIT = 4'b0000
  - event index constants EV_MODE = 0, EV_UP = 1, EV_DN = 2, EV_PAUSE = 3
- **Sub-module tick_gen:**
  - inputs: CW-bit prescaler, period input, clear, hold
  - output: one-cycle tick
  - reset is synchronous active-low on rest
- The top level holds the event-priority decode, mode/speed/pause registers and the pattern register.

## Test plan
All scenarios use TICK_DIV = 16.
- **Reset:** rest low 2 cycles → led = 1111, mode = 0, speed = 0, paused = 0.
- **RUN stepping:** key_evt = 0001 → mode = 1, led = 1110. Then led = 1101, 1011, 0111 at +16, +32, +48 cycles, and 1110 again at +64.
- **Speed limits:**
  - key_evt[1] pulsed 4 times → speed saturates at 3, period 2, and RUN steps every 2 cycles.
  - key_evt[2] pulsed 5 times → speed = 0.
- **COUNT wrap:** advance to mode 3 → led 1111, 1110, 1101, … every 16 cycles; after 16 ticks led returns to 1111 (count wrapped 15→0).
- **Pause / resume:**
  - key_evt[3] in BLINK → led frozen for 100 cycles, paused = 1.
  - key_evt[3] again → next invert exactly 16 cycles later.
- **Conflicts and mid-run reset:**
  - key_evt = 1011 on the same cycle as a tick → only paused toggles; mode/speed unchanged; no pattern step.
  - rest low for one cycle while in COUNT with count = 9 → all reset values next edge.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED mode sequencer: mode values, pattern seeds,
// key-event bit positions and the decoded single-event type.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  localparam logic [3:0] LED_OFF    = 4'b1111;
  localparam logic [3:0] RUN_INIT   = 4'b1110;
  localparam logic [3:0] BLINK_INIT = 4'b0000;

  localparam int EV_MODE  = 0;
  localparam int EV_UP    = 1;
  localparam int EV_DN    = 2;
  localparam int EV_PAUSE = 3;

  typedef enum logic [2:0] {
    EVT_NONE,
    EVT_PAUSE,
    EVT_MODE,
    EVT_UP,
    EVT_DN
  } evt_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_IDLE:  next_mode = MODE_RUN;
      MODE_RUN:   next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_COUNT;
      default:    next_mode = MODE_IDLE;
    endcase
  endfunction

  // COUNT starts from count = 0, which shows as all LEDs off.
  function automatic logic [3:0] mode_seed(input mode_e m);
    case (m)
      MODE_RUN:   mode_seed = RUN_INIT;
      MODE_BLINK: mode_seed = BLINK_INIT;
      default:    mode_seed = LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// Programmable prescaler: emits a one-cycle tick every `period` cycles,
// restartable by `clear` and frozen by `hold`.
module tick_gen #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rest,
  input  logic [CW-1:0] period,
  input  logic          clear,
  input  logic          hold,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !hold && (cnt_q == period - CW'(1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rest) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// 4-LED pattern sequencer: prioritised key events select mode, speed and
// pause; a prescaler tick advances the active-low pattern.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int CW       = 24
) (
  input  logic       clk,
  input  logic       rest,
  input  logic [3:0] key_evt,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused
);

  mode_e      mode_q, mode_d;
  logic [1:0] speed_q, speed_d;
  logic       paused_q, paused_d;
  logic [3:0] led_q, led_d;
  logic [3:0] count_q, count_d;
  logic [3:0] count_inc;

  evt_e          evt;
  logic          any_evt;
  logic          tick;
  logic [CW-1:0] period;

  assign period    = CW'(TICK_DIV) >> speed_q;
  assign any_evt   = (evt != EVT_NONE);
  assign count_inc = count_q + 4'd1;

  // Only the highest-priority pressed key is honoured; the rest are dropped.
  always_comb begin
    evt = EVT_NONE;
    if      (key_evt[EV_PAUSE]) evt = EVT_PAUSE;
    else if (key_evt[EV_MODE])  evt = EVT_MODE;
    else if (key_evt[EV_UP])    evt = EVT_UP;
    else if (key_evt[EV_DN])    evt = EVT_DN;
  end

  tick_gen #(.CW(CW)) u_tick_gen (
    .clk    (clk),
    .rest   (rest),
    .period (period),
    .clear  (any_evt),
    .hold   (paused_q),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rest) begin
      mode_q   <= MODE_IDLE;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      led_q    <= LED_OFF;
      count_q  <= 4'd0;
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      led_q    <= led_d;
      count_q  <= count_d;
    end
  end

  // An honoured event always beats a coincident tick.
  always_comb begin
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    led_d    = led_q;
    count_d  = count_q;
    unique case (evt)
      EVT_PAUSE: paused_d = !paused_q;
      EVT_MODE: begin
        mode_d  = next_mode(mode_q);
        led_d   = mode_seed(mode_d);
        count_d = 4'd0;
      end
      EVT_UP:   if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
      EVT_DN:   if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
      EVT_NONE: begin
        if (tick) begin
          case (mode_q)
            MODE_IDLE:  led_d = LED_OFF;
            MODE_RUN:   led_d = {led_q[2:0], led_q[3]};
            MODE_BLINK: led_d = ~led_q;
            MODE_COUNT: begin
              count_d = count_inc;
              led_d   = ~count_inc;
            end
          endcase
        end
      end
    endcase
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl at TICK_DIV = 16: reset, RUN stepping,
// speed saturation, COUNT wrap, pause/resume, conflicts and mid-run reset.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rest;
  logic [3:0] key_evt;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;

  int n_vec  = 0;
  int n_miss = 0;

  led_mode_ctrl #(.TICK_DIV(16), .CW(24)) dut (
    .clk     (clk),
    .rest    (rest),
    .key_evt (key_evt),
    .led     (led),
    .mode    (mode),
    .speed   (speed),
    .paused  (paused)
  );

  always #5 clk = ~clk;

  // Advance n posedges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_evt = k;
    step(1);
    key_evt = 4'b0000;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] l, input logic [1:0] m,
                             input logic [1:0] s, input logic p);
    check({tag, ".led"},    led,             l);
    check({tag, ".mode"},   {2'b00, mode},   {2'b00, m});
    check({tag, ".speed"},  {2'b00, speed},  {2'b00, s});
    check({tag, ".paused"}, {3'b000, paused}, {3'b000, p});
  endtask

  initial begin
    logic [3:0] c;
    rest    = 1'b0;
    key_evt = 4'b0000;
    step(2);
    rest = 1'b1;
    check_state("reset", 4'b1111, 2'd0, 2'd0, 1'b0);

    // RUN stepping at period 16
    press(4'b0001);
    check_state("run_enter", 4'b1110, 2'd1, 2'd0, 1'b0);
    step(15);
    check("run_before_tick", led, 4'b1110);
    step(1);
    check("run_step1", led, 4'b1101);
    step(16);
    check("run_step2", led, 4'b1011);
    step(16);
    check("run_step3", led, 4'b0111);
    step(16);
    check("run_wrap", led, 4'b1110);

    // Speed up saturates at 3 (period 2)
    repeat (4) press(4'b0010);
    check_state("speed_max", 4'b1110, 2'd1, 2'd3, 1'b0);
    step(1);
    check("fast_no_tick", led, 4'b1110);
    step(1);
    check("fast_step1", led, 4'b1101);
    step(2);
    check("fast_step2", led, 4'b1011);

    // Speed down saturates at 0
    repeat (5) press(4'b0100);
    check_state("speed_min", 4'b1011, 2'd1, 2'd0, 1'b0);

    // COUNT wrap
    press(4'b0001);
    check_state("blink_enter", 4'b0000, 2'd2, 2'd0, 1'b0);
    press(4'b0001);
    check_state("count_enter", 4'b1111, 2'd3, 2'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(16);
      c = 4'(i);
      check($sformatf("count_%0d", i), led, ~c);
    end

    // Pause / resume in BLINK
    press(4'b0001);
    check("idle_again", {2'b00, mode}, 4'd0);
    press(4'b0001);
    press(4'b0001);
    check_state("blink2", 4'b0000, 2'd2, 2'd0, 1'b0);
    step(16);
    check("blink_invert", led, 4'b1111);
    step(5);
    press(4'b1000);
    check_state("pause_on", 4'b1111, 2'd2, 2'd0, 1'b1);
    step(100);
    check_state("pause_hold", 4'b1111, 2'd2, 2'd0, 1'b1);
    press(4'b1000);
    check("resume_paused", {3'b000, paused}, 4'd0);
    step(15);
    check("resume_before_tick", led, 4'b1111);
    step(1);
    check("resume_invert", led, 4'b0000);

    // Multi-key event coinciding with a tick: only pause honoured
    step(15);
    key_evt = 4'b1011;
    step(1);
    key_evt = 4'b0000;
    check_state("conflict", 4'b0000, 2'd2, 2'd0, 1'b1);
    step(20);
    check("conflict_frozen", led, 4'b0000);
    press(4'b1000);
    check("conflict_resume", {3'b000, paused}, 4'd0);

    // Mid-run reset in COUNT with count = 9, while paused
    press(4'b0001);
    check_state("count2_enter", 4'b1111, 2'd3, 2'd0, 1'b0);
    repeat (9) step(16);
    check("count_9", led, 4'b0110);
    press(4'b0010);
    press(4'b1000);
    check_state("pre_reset", 4'b0110, 2'd3, 2'd1, 1'b1);
    step(3);
    rest = 1'b0;
    step(1);
    rest = 1'b1;
    check_state("mid_reset", 4'b1111, 2'd0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
